// File: rtl/cc_muxx_read.sv
// rtl/cc_muxx_read.sv - register-file read mux with a one-entry operand holding stage
//
// Purpose:
//   Selects an A/B address pair (scratchpad or MIR). Each address is mapped onto
//   a 14-entry flattened register file, and the two operands are registered into
//   a single-slot EMPTY/FULL stage with valid/ack handshaking. Addresses outside
//   DATA_REGBASE..DATA_REGBASE+13 read as zero.
//
// Optional feature (macro CC_MUXX_READ_BYPASS_EN):
//   When defined, an operand whose selected entry has its active-low load strobe
//   asserted in the accept cycle captures WriteData_InBus instead of the entry.
//
// Ports:
//   CC_MUXX_READ_CLOCK_50          in   clock, rising edge
//   CC_MUXX_READ_RESET_InLow       in   asynchronous active-low reset
//   CC_MUXX_READ_Req_In            in   read request
//   CC_MUXX_READ_Ready_Out         out  request can be accepted (combinational)
//   CC_MUXX_READ_Select_In         in   address source: 0 scratchpad, 1 MIR
//   CC_MUXX_READ_MIRA_InBus        in   MIR A address
//   CC_MUXX_READ_MIRB_InBus        in   MIR B address
//   CC_MUXX_READ_ScratchpadA_InBus in   scratchpad A address
//   CC_MUXX_READ_ScratchpadB_InBus in   scratchpad B address
//   CC_MUXX_READ_RegFile_InBus     in   flattened register file, entry k at [32k+31:32k]
//   CC_MUXX_READ_Load_InBus        in   active-low per-entry write strobes
//   CC_MUXX_READ_WriteData_InBus   in   write-back data
//   CC_MUXX_READ_A_OutBus          out  registered A operand
//   CC_MUXX_READ_B_OutBus          out  registered B operand
//   CC_MUXX_READ_Valid_Out         out  operands valid
//   CC_MUXX_READ_Ack_In            in   consumer accepts operands
//   CC_MUXX_READ_Count_OutBus      out  count of accepted reads (wraps)

module cc_muxx_read #(
  parameter int DATAWIDTH_BUS                  = 32,
  parameter int DATAWIDTH_MIR_SELECTION        = 6,
  parameter int DATAWIDTH_SCRATCHPAD_SELECTION = 5,
  parameter int DATAWIDTH_DECODER_OUT          = 14,
  parameter logic [DATAWIDTH_MIR_SELECTION-1:0] DATA_REGBASE = 6'b000010
) (
  input  logic                                            CC_MUXX_READ_CLOCK_50,
  input  logic                                            CC_MUXX_READ_RESET_InLow,
  input  logic                                            CC_MUXX_READ_Req_In,
  output logic                                            CC_MUXX_READ_Ready_Out,
  input  logic                                            CC_MUXX_READ_Select_In,
  input  logic [DATAWIDTH_MIR_SELECTION-1:0]              CC_MUXX_READ_MIRA_InBus,
  input  logic [DATAWIDTH_MIR_SELECTION-1:0]              CC_MUXX_READ_MIRB_InBus,
  input  logic [DATAWIDTH_SCRATCHPAD_SELECTION-1:0]       CC_MUXX_READ_ScratchpadA_InBus,
  input  logic [DATAWIDTH_SCRATCHPAD_SELECTION-1:0]       CC_MUXX_READ_ScratchpadB_InBus,
  input  logic [DATAWIDTH_BUS*DATAWIDTH_DECODER_OUT-1:0]  CC_MUXX_READ_RegFile_InBus,
  input  logic [DATAWIDTH_DECODER_OUT-1:0]                CC_MUXX_READ_Load_InBus,
  input  logic [DATAWIDTH_BUS-1:0]                        CC_MUXX_READ_WriteData_InBus,
  output logic [DATAWIDTH_BUS-1:0]                        CC_MUXX_READ_A_OutBus,
  output logic [DATAWIDTH_BUS-1:0]                        CC_MUXX_READ_B_OutBus,
  output logic                                            CC_MUXX_READ_Valid_Out,
  input  logic                                            CC_MUXX_READ_Ack_In,
  output logic [15:0]                                     CC_MUXX_READ_Count_OutBus
);

  localparam int AW = DATAWIDTH_MIR_SELECTION;
  localparam int SW = DATAWIDTH_SCRATCHPAD_SELECTION;
  localparam logic [AW-1:0] L_ENTRIES = AW'(DATAWIDTH_DECODER_OUT);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic                     w_ready;
  logic                     w_accept;
  logic [AW-1:0]            w_addr_a;
  logic [AW-1:0]            w_addr_b;
  logic [AW-1:0]            w_off_a;
  logic [AW-1:0]            w_off_b;
  logic                     w_hit_a;
  logic                     w_hit_b;
  logic [DATAWIDTH_BUS-1:0] w_data_a;
  logic [DATAWIDTH_BUS-1:0] w_data_b;
  logic [DATAWIDTH_BUS-1:0] r_a;
  logic [DATAWIDTH_BUS-1:0] r_b;
  logic [15:0]              r_count;

  // Scratchpad addresses are zero-extended to the MIR address width.
  assign w_addr_a = CC_MUXX_READ_Select_In ? CC_MUXX_READ_MIRA_InBus
                                           : {{(AW-SW){1'b0}}, CC_MUXX_READ_ScratchpadA_InBus};
  assign w_addr_b = CC_MUXX_READ_Select_In ? CC_MUXX_READ_MIRB_InBus
                                           : {{(AW-SW){1'b0}}, CC_MUXX_READ_ScratchpadB_InBus};

  // Offset wraps when addr < base, so the explicit lower-bound test is required.
  assign w_off_a = w_addr_a - DATA_REGBASE;
  assign w_off_b = w_addr_b - DATA_REGBASE;
  assign w_hit_a = (w_addr_a >= DATA_REGBASE) && (w_off_a < L_ENTRIES);
  assign w_hit_b = (w_addr_b >= DATA_REGBASE) && (w_off_b < L_ENTRIES);

  // Entry mux unrolled over constant slices; misses fall through to zero.
  always_comb begin
    w_data_a = '0;
    w_data_b = '0;
    for (int k = 0; k < DATAWIDTH_DECODER_OUT; k++) begin
      if (w_hit_a && (w_off_a == AW'(k))) begin
        w_data_a = CC_MUXX_READ_RegFile_InBus[k*DATAWIDTH_BUS +: DATAWIDTH_BUS];
`ifdef CC_MUXX_READ_BYPASS_EN
        if (!CC_MUXX_READ_Load_InBus[k]) w_data_a = CC_MUXX_READ_WriteData_InBus;
`endif
      end
      if (w_hit_b && (w_off_b == AW'(k))) begin
        w_data_b = CC_MUXX_READ_RegFile_InBus[k*DATAWIDTH_BUS +: DATAWIDTH_BUS];
`ifdef CC_MUXX_READ_BYPASS_EN
        if (!CC_MUXX_READ_Load_InBus[k]) w_data_b = CC_MUXX_READ_WriteData_InBus;
`endif
      end
    end
  end

`ifndef CC_MUXX_READ_BYPASS_EN
  logic w_unused_bypass;
  assign w_unused_bypass = ^{CC_MUXX_READ_Load_InBus, CC_MUXX_READ_WriteData_InBus};
`endif

  always_ff @(posedge CC_MUXX_READ_CLOCK_50 or negedge CC_MUXX_READ_RESET_InLow) begin
    if (!CC_MUXX_READ_RESET_InLow) r_state <= S_EMPTY;
    else                           r_state <= w_state_next;
  end

  // Slot frees in the same cycle it is acknowledged, allowing one read per cycle.
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b1;
    w_accept     = 1'b0;
    case (r_state)
      S_EMPTY: begin
        w_ready  = 1'b1;
        w_accept = CC_MUXX_READ_Req_In;
        if (w_accept) w_state_next = S_FULL;
      end
      S_FULL: begin
        w_ready  = CC_MUXX_READ_Ack_In;
        w_accept = CC_MUXX_READ_Req_In && CC_MUXX_READ_Ack_In;
        if (CC_MUXX_READ_Ack_In && !w_accept) w_state_next = S_EMPTY;
      end
      default: w_state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge CC_MUXX_READ_CLOCK_50 or negedge CC_MUXX_READ_RESET_InLow) begin
    if (!CC_MUXX_READ_RESET_InLow) begin
      r_a     <= '0;
      r_b     <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_a     <= w_data_a;
      r_b     <= w_data_b;
      r_count <= r_count + 16'd1;
    end
  end

  assign CC_MUXX_READ_Ready_Out    = w_ready;
  assign CC_MUXX_READ_A_OutBus     = r_a;
  assign CC_MUXX_READ_B_OutBus     = r_b;
  assign CC_MUXX_READ_Valid_Out    = (r_state == S_FULL);
  assign CC_MUXX_READ_Count_OutBus = r_count;

endmodule

// File: tb/tb_cc_muxx_read.sv
// tb/tb_cc_muxx_read.sv - directed self-checking bench for cc_muxx_read

module tb_cc_muxx_read;

  logic         clk;
  logic         rst_n;
  logic         req;
  logic         ready;
  logic         sel;
  logic [5:0]   mira;
  logic [5:0]   mirb;
  logic [4:0]   spa;
  logic [4:0]   spb;
  logic [447:0] rf;
  logic [13:0]  load;
  logic [31:0]  wdata;
  logic [31:0]  a_out;
  logic [31:0]  b_out;
  logic         valid;
  logic         ack;
  logic [15:0]  count;

  int tests_run = 0;
  int tests_failed = 0;
  logic [15:0] exp_count;

  cc_muxx_read dut (
    .CC_MUXX_READ_CLOCK_50          (clk),
    .CC_MUXX_READ_RESET_InLow       (rst_n),
    .CC_MUXX_READ_Req_In            (req),
    .CC_MUXX_READ_Ready_Out         (ready),
    .CC_MUXX_READ_Select_In         (sel),
    .CC_MUXX_READ_MIRA_InBus        (mira),
    .CC_MUXX_READ_MIRB_InBus        (mirb),
    .CC_MUXX_READ_ScratchpadA_InBus (spa),
    .CC_MUXX_READ_ScratchpadB_InBus (spb),
    .CC_MUXX_READ_RegFile_InBus     (rf),
    .CC_MUXX_READ_Load_InBus        (load),
    .CC_MUXX_READ_WriteData_InBus   (wdata),
    .CC_MUXX_READ_A_OutBus          (a_out),
    .CC_MUXX_READ_B_OutBus          (b_out),
    .CC_MUXX_READ_Valid_Out         (valid),
    .CC_MUXX_READ_Ack_In            (ack),
    .CC_MUXX_READ_Count_OutBus      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entry k defaults to 32'hA000_0000 + k.
  task automatic init_rf();
    for (int k = 0; k < 14; k++) rf[k*32 +: 32] = 32'hA000_0000 + 32'(k);
    load  = 14'h3FFF;
    wdata = 32'hDEAD_BEEF;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; ack = 1'b0; sel = 1'b0;
    mira = '0; mirb = '0; spa = '0; spb = '0;
    init_rf();
    #12;
    tests_run++;
    if ({valid, a_out, b_out, count} !== 81'd0) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%b a=%h b=%h count=%h, expected all zero", valid, a_out, b_out, count);
    end
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b expected 1", ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 16'd0;
    step();
  endtask

  task automatic test_mir_read();
    init_rf();
    rf[0*32 +: 32]  = 32'h1111_1111;
    rf[13*32 +: 32] = 32'hDDDD_DDDD;
    sel = 1'b1; mira = 6'd2; mirb = 6'd15; req = 1'b1; ack = 1'b0;
    step();
    req = 1'b0;
    exp_count = exp_count + 16'd1;
    tests_run++;
    if (valid !== 1'b1 || a_out !== 32'h1111_1111 || b_out !== 32'hDDDD_DDDD || count !== exp_count) begin
      tests_failed++;
      $display("FAIL mir_read: valid=%b a=%h b=%h count=%h, expected 1 11111111 dddddddd %h",
               valid, a_out, b_out, count, exp_count);
    end
    tests_run++;
    if (ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL mir_read_ready: got %b expected 0", ready);
    end
  endtask

  task automatic test_hold();
    req = 1'b1; ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 14; k++) rf[k*32 +: 32] = 32'h5555_0000 + 32'(i*16 + k);
      mira = 6'(3 + i); mirb = 6'(4 + i);
      step();
      tests_run++;
      if (valid !== 1'b1 || a_out !== 32'h1111_1111 || b_out !== 32'hDDDD_DDDD ||
          count !== exp_count || ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_%0d: valid=%b a=%h b=%h count=%h ready=%b, expected 1 11111111 dddddddd %h 0",
                 i, valid, a_out, b_out, count, ready, exp_count);
      end
    end
    init_rf();
    mira = 6'd3; mirb = 6'd4; ack = 1'b1; req = 1'b1;
    step();
    exp_count = exp_count + 16'd1;
    tests_run++;
    if (valid !== 1'b1 || a_out !== 32'hA000_0001 || b_out !== 32'hA000_0002 || count !== exp_count) begin
      tests_failed++;
      $display("FAIL hold_release: valid=%b a=%h b=%h count=%h, expected 1 a0000001 a0000002 %h",
               valid, a_out, b_out, count, exp_count);
    end
    req = 1'b0;
    step();
    tests_run++;
    if (valid !== 1'b0 || count !== exp_count || a_out !== 32'hA000_0001) begin
      tests_failed++;
      $display("FAIL ack_drain: valid=%b count=%h a=%h, expected 0 %h a0000001", valid, count, a_out, exp_count);
    end
  endtask

  task automatic test_ack_empty();
    ack = 1'b1; req = 1'b0;
    repeat (3) step();
    tests_run++;
    if (valid !== 1'b0 || count !== exp_count || ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ack_empty: valid=%b count=%h ready=%b, expected 0 %h 1", valid, count, ready, exp_count);
    end
  endtask

  // Back-to-back reads covering both address sources and the range boundaries.
  task automatic test_back_to_back();
    logic        v_sel [5];
    logic [5:0]  v_a   [5];
    logic [5:0]  v_b   [5];
    logic [31:0] v_ea  [5];
    logic [31:0] v_eb  [5];
    v_sel = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    v_a   = '{6'd1, 6'd1, 6'd2, 6'd63, 6'd31};
    v_b   = '{6'd16, 6'd16, 6'd15, 6'd0, 6'd9};
    v_ea  = '{32'h0, 32'h0, 32'hA000_0000, 32'h0, 32'h0};
    v_eb  = '{32'h0, 32'h0, 32'hA000_000D, 32'h0, 32'hA000_0007};
    init_rf();
    ack = 1'b1;
    req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sel  = v_sel[i];
      mira = v_a[i];  mirb = v_b[i];
      spa  = v_a[i][4:0]; spb = v_b[i][4:0];
      if (v_sel[i]) begin spa = 5'd2; spb = 5'd2; end
      else          begin mira = 6'd2; mirb = 6'd2; end
      step();
      exp_count = exp_count + 16'd1;
      tests_run++;
      if (valid !== 1'b1 || a_out !== v_ea[i] || b_out !== v_eb[i] || count !== exp_count) begin
        tests_failed++;
        $display("FAIL b2b_%0d: valid=%b a=%h b=%h count=%h, expected 1 %h %h %h",
                 i, valid, a_out, b_out, count, v_ea[i], v_eb[i], exp_count);
      end
    end
    req = 1'b0;
    step();
  endtask

  task automatic test_same_entry();
    init_rf();
    sel = 1'b1; mira = 6'd7; mirb = 6'd7; req = 1'b1; ack = 1'b1;
    step();
    req = 1'b0;
    exp_count = exp_count + 16'd1;
    tests_run++;
    if (a_out !== 32'hA000_0005 || b_out !== 32'hA000_0005) begin
      tests_failed++;
      $display("FAIL same_entry: a=%h b=%h, expected a0000005 a0000005", a_out, b_out);
    end
    step();
  endtask

  task automatic test_bypass();
    logic [31:0] exp_a;
`ifdef CC_MUXX_READ_BYPASS_EN
    exp_a = 32'hCAFE_F00D;
`else
    exp_a = 32'h0;
`endif
    init_rf();
    rf[3*32 +: 32] = 32'h0;
    load  = 14'b11111111110111;
    wdata = 32'hCAFE_F00D;
    sel = 1'b1; mira = 6'd5; mirb = 6'd6; req = 1'b1; ack = 1'b1;
    step();
    req = 1'b0;
    exp_count = exp_count + 16'd1;
    tests_run++;
    if (a_out !== exp_a || b_out !== 32'hA000_0004 || count !== exp_count) begin
      tests_failed++;
      $display("FAIL bypass: a=%h b=%h count=%h, expected %h a0000004 %h", a_out, b_out, count, exp_a, exp_count);
    end
    init_rf();
    step();
  endtask

  task automatic test_reset_mid_hold();
    init_rf();
    sel = 1'b1; mira = 6'd4; mirb = 6'd5; req = 1'b1; ack = 1'b0;
    step();
    exp_count = exp_count + 16'd1;
    tests_run++;
    if (valid !== 1'b1 || a_out !== 32'hA000_0002 || count !== exp_count) begin
      tests_failed++;
      $display("FAIL pre_reset_hold: valid=%b a=%h count=%h, expected 1 a0000002 %h", valid, a_out, count, exp_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({valid, a_out, b_out, count} !== 81'd0) begin
      tests_failed++;
      $display("FAIL async_reset: valid=%b a=%h b=%h count=%h, expected all zero", valid, a_out, b_out, count);
    end
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    exp_count = 16'd0;
    tests_run++;
    if (valid !== 1'b0 || count !== 16'd0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: valid=%b count=%h, expected 0 0000", valid, count);
    end
  endtask

  task automatic test_count_wrap();
    ack = 1'b1; req = 1'b1; sel = 1'b1; mira = 6'd2; mirb = 6'd3;
    repeat (65535) @(posedge clk);
    #1;
    tests_run++;
    if (count !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL count_preload: got %h expected ffff", count);
    end
    step();
    req = 1'b0;
    tests_run++;
    if (count !== 16'h0000 || valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL count_wrap: count=%h valid=%b, expected 0000 1", count, valid);
    end
  endtask

  initial begin
    test_reset();
    test_mir_read();
    test_hold();
    test_ack_empty();
    test_back_to_back();
    test_same_entry();
    test_bypass();
    test_reset_mid_hold();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
